// File: rtl/seg7_scan_decoder.sv
// Multiplexed active-low 7-segment bus decoder: synchronizes the scan lines, qualifies
// each digit pattern by stability, decodes it to BCD and issues complete frames over valid/ready.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic [4*NUM_DIGITS-1:0]   digit_bcd,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic [4*NUM_DIGITS-1:0]   frame_bcd,
    output logic [NUM_DIGITS-1:0]     frame_err,
    output logic                      frame_valid,
    input  logic                      frame_ready
);

    localparam int unsigned SW         = NUM_DIGITS + 7;
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [SW-1:0]         sync1;
    logic [SW-1:0]         sync2;
    logic [SW-1:0]         prev;
    logic [7:0]            stab_cnt;
    logic [7:0]            stab_cnt_nxt;
    logic [6:0]            samp_seg;
    logic [NUM_DIGITS-1:0] sel_mask;
    logic                  sel_valid;
    logic                  capture;
    logic [NUM_DIGITS-1:0] capture_mask;
    logic [3:0]            dec_bcd;
    logic                  dec_err;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic [0:0]            state;
    logic                  accept;

    // Reset to all-ones so the pipeline starts out blank with no digit selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {dig_sel_n, seg_in};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign samp_seg = sync2[6:0];
    assign sel_mask = ~sync2[SW-1:7];
    assign sel_valid = (sel_mask != '0) &&
                       ((sel_mask & (sel_mask - NUM_DIGITS'(1))) == '0);

    always_comb begin
        if (sync2 != prev) begin
            stab_cnt_nxt = 8'd1;
        end else if (stab_cnt == STABLE_MAX) begin
            stab_cnt_nxt = stab_cnt;
        end else begin
            stab_cnt_nxt = stab_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt_nxt;
        end
    end

    // Strobe on the edge where the count first reaches the threshold, so a long hold captures once.
    assign capture      = (stab_cnt_nxt == STABLE_MAX) && (stab_cnt != STABLE_MAX) && sel_valid;
    assign capture_mask = capture ? sel_mask : '0;

    always_comb begin
        dec_bcd = 4'hF;
        dec_err = 1'b0;
        case (samp_seg)
            7'b1000000: dec_bcd = 4'd0;
            7'b1111001: dec_bcd = 4'd1;
            7'b0100100: dec_bcd = 4'd2;
            7'b0110000: dec_bcd = 4'd3;
            7'b0011001: dec_bcd = 4'd4;
            7'b0010010: dec_bcd = 4'd5;
            7'b0000010: dec_bcd = 4'd6;
            7'b1111000: dec_bcd = 4'd7;
            7'b0000000: dec_bcd = 4'd8;
            7'b0011000: dec_bcd = 4'd9;
            default: begin
                dec_bcd = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_bcd <= '0;
            digit_err <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture_mask[i]) begin
                    digit_bcd[4*i +: 4] <= dec_bcd;
                    digit_err[i]        <= dec_err;
                end
            end
        end
    end

    assign accept = (state == PENDING) && frame_ready;

    // A capture on the accept edge counts toward the next frame, so set wins over clear.
    assign seen_nxt = (accept ? '0 : seen) | capture_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
        end else begin
            seen <= seen_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            frame_bcd <= '0;
            frame_err <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (&seen) begin
                        state     <= PENDING;
                        frame_bcd <= digit_bcd;
                        frame_err <= digit_err;
                    end
                end
                PENDING: begin
                    if (frame_ready) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign frame_valid = (state == PENDING);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued as scans are driven
// and compared when a frame transfers; direct checks cover capture timing, errors and reset.
module tb_seg7_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   err;
    } frame_t;

    logic            clk;
    logic            rst_n;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel_n;
    logic [4*ND-1:0] digit_bcd;
    logic [ND-1:0]   digit_err;
    logic [4*ND-1:0] frame_bcd;
    logic [ND-1:0]   frame_err;
    logic            frame_valid;
    logic            frame_ready;

    int n_checks = 0;
    int n_fail   = 0;
    frame_t sb[$];

    seg7_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel_n  (dig_sel_n),
        .digit_bcd  (digit_bcd),
        .digit_err  (digit_err),
        .frame_bcd  (frame_bcd),
        .frame_err  (frame_err),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [ND-1:0] onecold(input int d);
        logic [ND-1:0] r;
        r = '1;
        r[d] = 1'b0;
        return r;
    endfunction

    // Inputs change 1ns after a rising edge and are held for n edges.
    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] pat, input int n);
        dig_sel_n = sel;
        seg_in    = pat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic blank(input int n);
        drive('1, 7'h7F, n);
    endtask

    task automatic scan(input logic [4*ND-1:0] vals);
        for (int i = 0; i < ND; i++) begin
            drive(onecold(i), seg7(vals[4*i +: 4]), 6);
        end
    endtask

    task automatic push(input logic [4*ND-1:0] bcd, input logic [ND-1:0] err);
        frame_t f;
        f.bcd = bcd;
        f.err = err;
        sb.push_back(f);
    endtask

    // Inputs are stable at the falling edge, so valid&ready here means a transfer on the next rise.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                frame_t e;
                e = sb.pop_front();
                check("sb_frame_bcd", frame_bcd, e.bcd);
                check("sb_frame_err", frame_err, e.err);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        seg_in      = '1;
        dig_sel_n   = '1;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_digit_bcd", digit_bcd, 0);
        rst_n = 1'b1;

        // Idle with everything blank: nothing may capture.
        blank(100);
        check("idle_digit_bcd", digit_bcd, 0);
        check("idle_digit_err", digit_err, 0);
        check("idle_frame_bcd", frame_bcd, 0);
        check("idle_frame_err", frame_err, 0);
        check("idle_frame_valid", frame_valid, 0);

        // First full scan; frame rises one cycle after the last capture.
        push(16'h4321, 4'b0000);
        scan(16'h4321);
        check("scan1_digit_bcd", digit_bcd, 16'h4321);
        check("scan1_digit_err", digit_err, 0);
        check("scan1_valid_early", frame_valid, 0);
        blank(1);
        check("scan1_frame_valid", frame_valid, 1);
        check("scan1_frame_bcd", frame_bcd, 16'h4321);
        check("scan1_frame_err", frame_err, 0);

        // Too-short pattern and a multi-low select never capture.
        drive(onecold(0), seg7(4'd2), 3);
        blank(8);
        check("short_digit0", digit_bcd[3:0], 4'd1);
        drive(4'b1100, seg7(4'd5), 10);
        blank(2);
        check("multisel_digit_bcd", digit_bcd, 16'h4321);
        check("multisel_digit_err", digit_err, 0);

        // Rescan while the frame is held; outputs stay frozen.
        scan(16'h9999);
        check("hold_digit_bcd", digit_bcd, 16'h9999);
        check("hold_frame_bcd", frame_bcd, 16'h4321);
        check("hold_frame_valid", frame_valid, 1);

        // Accept on the same edge that recaptures digit 0.
        drive(onecold(0), seg7(4'd9), SC + 1);
        frame_ready = 1'b1;
        drive(onecold(0), seg7(4'd9), 1);
        frame_ready = 1'b0;
        check("accept_valid_fall", frame_valid, 0);
        push(16'h9999, 4'b0000);
        frame_ready = 1'b1;
        drive(onecold(1), seg7(4'd9), 6);
        frame_ready = 1'b0;
        check("collect_ready_ignored", frame_valid, 0);
        drive(onecold(2), seg7(4'd9), 6);
        check("partial_no_valid", frame_valid, 0);
        drive(onecold(3), seg7(4'd9), 6);
        check("d3_capture_valid_low", frame_valid, 0);
        blank(1);
        check("coincident_frame_valid", frame_valid, 1);
        check("coincident_frame_bcd", frame_bcd, 16'h9999);
        frame_ready = 1'b1;
        blank(1);
        frame_ready = 1'b0;
        check("accept2_valid_fall", frame_valid, 0);
        blank(10);
        check("no_reissue", frame_valid, 0);

        // Illegal pattern on digit 2 plus the 0 and 8 patterns.
        push(16'h7F08, 4'b0100);
        scan(16'h7F08);
        check("illegal_digit2", digit_bcd[11:8], 4'hF);
        check("illegal_digit_err", digit_err, 4'b0100);
        check("illegal_digit_bcd", digit_bcd, 16'h7F08);
        blank(1);
        check("illegal_frame_valid", frame_valid, 1);
        check("illegal_frame_err", frame_err, 4'b0100);
        frame_ready = 1'b1;
        blank(1);
        frame_ready = 1'b0;

        // Asynchronous reset drops a pending frame.
        scan(16'h5678);
        blank(1);
        check("pre_reset_valid", frame_valid, 1);
        check("pre_reset_frame_bcd", frame_bcd, 16'h5678);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", frame_valid, 0);
        check("async_rst_frame_bcd", frame_bcd, 0);
        check("async_rst_digit_bcd", digit_bcd, 0);
        check("async_rst_errs", {digit_err, frame_err}, 0);
        @(posedge clk);
        #1;
        blank(2);
        rst_n = 1'b1;
        blank(3);
        drive(onecold(0), seg7(4'd1), 6);
        drive(onecold(1), seg7(4'd5), 6);
        drive(onecold(2), seg7(4'd9), 6);
        blank(3);
        check("post_rst_partial_valid", frame_valid, 0);
        check("post_rst_partial_bcd", digit_bcd, 16'h0951);
        push(16'h3951, 4'b0000);
        drive(onecold(3), seg7(4'd3), 6);
        blank(1);
        check("post_rst_frame_valid", frame_valid, 1);
        check("post_rst_frame_bcd", frame_bcd, 16'h3951);
        frame_ready = 1'b1;
        blank(1);
        frame_ready = 1'b0;
        blank(3);
        check("sb_drained", sb.size(), 0);
        check("final_valid", frame_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
